// File: rtl/prog_loader.sv
// prog_loader: streams a program image into CPU memory, then releases the CPU until it halts.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte verified before RUN.
module prog_loader #(
  parameter int MEM_AW = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [MEM_AW-1:0] Len,
  input  logic [7:0]        DataIn,
  input  logic              DataValid,
  output logic              DataReady,
  output logic [MEM_AW-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic              MemWr,
  input  logic              Halt,
  output logic              CpuRun,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);
`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, HALTED} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HALTED} state_t;
`endif
  state_t r_state, w_next;
  logic [MEM_AW-1:0] r_len, r_cnt, r_mem_addr, w_cnt_nxt;
  logic [7:0] r_mem_data;
  logic r_mem_wr, r_done, w_accept, w_start, w_last, w_load_acc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic r_err, w_chk_acc;
  assign Busy      = (r_state == LOAD) || (r_state == CHECK);
  assign w_chk_acc = (r_state == CHECK) && w_accept;
  assign Err       = r_err;
`else
  assign Busy      = (r_state == LOAD);
  assign Err       = 1'b0;
`endif
  assign DataReady  = Busy;
  assign CpuRun     = (r_state == RUN);
  assign w_accept   = DataValid && DataReady;
  assign w_start    = Start && ((r_state == IDLE) || (r_state == HALTED));
  assign w_load_acc = (r_state == LOAD) && w_accept;
  assign w_cnt_nxt  = r_cnt + 1'b1;
  // Len=0 lands here after the counter wraps, giving a full 2**MEM_AW load
  assign w_last     = (w_cnt_nxt == r_len);
  assign MemAddr    = r_mem_addr;
  assign MemData    = r_mem_data;
  assign MemWr      = r_mem_wr;
  assign Done       = r_done;

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, HALTED: w_next = Start ? LOAD : r_state;
`ifdef PROG_LOADER_CHECKSUM_EN
      LOAD:         w_next = (w_accept && w_last) ? CHECK : LOAD;
      CHECK:        w_next = w_accept ? ((DataIn == r_sum) ? RUN : IDLE) : CHECK;
`else
      LOAD:         w_next = (w_accept && w_last) ? RUN : LOAD;
`endif
      RUN:          w_next = Halt ? HALTED : RUN;
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_len      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
      r_done     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_mem_wr <= w_load_acc;
      r_done   <= (w_next == RUN) && (r_state != RUN);
      if (w_load_acc) begin
        r_mem_addr <= r_cnt;
        r_mem_data <= DataIn;
        r_cnt      <= w_cnt_nxt;
      end
      if (w_start) begin
        r_len <= Len;
        r_cnt <= '0;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (w_load_acc) r_sum <= r_sum + DataIn;
      if (w_chk_acc && (DataIn != r_sum)) r_err <= 1'b1;
      if (w_start) begin
        r_sum <= '0;
        r_err <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table of program loads plus reset, halt and checksum sequences.
module tb_prog_loader;
  logic       Clock = 1'b0, Reset, Start, DataValid, Halt;
  logic [4:0] Len, MemAddr;
  logic [7:0] DataIn, MemData;
  logic       DataReady, MemWr, CpuRun, Busy, Done, Err;
  int total = 0, bad = 0;

  prog_loader #(.MEM_AW(5)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Len(Len), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(DataReady), .MemAddr(MemAddr), .MemData(MemData),
    .MemWr(MemWr), .Halt(Halt), .CpuRun(CpuRun), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0] len;
    int         gap;
    logic [7:0] base;
    logic [7:0] step;
    int         exp_n;
  } vec_t;
  vec_t vt[5];

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input logic [4:0] len, input int gap, input logic [7:0] base,
                          input logic [7:0] step, input int exp_n);
    logic [7:0] b, sum;
    sum = 8'h00;
    Start = 1'b1; Len = len; tick; Start = 1'b0; Len = 5'd0;
    chk("busy_start", Busy, 1); chk("ready_start", DataReady, 1);
    chk("err_clr", Err, 0); chk("run_off_load", CpuRun, 0);
    for (int i = 0; i < exp_n; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) begin
          DataValid = 1'b0; tick;
          chk("gap_wr", MemWr, 0); chk("gap_busy", Busy, 1); chk("gap_err", Err, 0);
        end
      b = base + 8'(i) * step;
      sum = sum + b;
      DataValid = 1'b1; DataIn = b; tick;
      chk("wr", MemWr, 1); chk("addr", MemAddr, 32'(i[4:0])); chk("data", MemData, b);
    end
    DataValid = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("check_ready", DataReady, 1); chk("check_busy", Busy, 1); chk("check_done", Done, 0);
    DataValid = 1'b1; DataIn = sum; tick; DataValid = 1'b0;
    chk("check_wr", MemWr, 0);
`endif
    chk("done", Done, 1); chk("cpurun", CpuRun, 1);
    chk("busy_end", Busy, 0); chk("ready_end", DataReady, 0);
    tick;
    chk("done_pulse", Done, 0); chk("wr_after", MemWr, 0); chk("run_hold", CpuRun, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{5'd3, 0, 8'h11, 8'h11, 3};
    vt[1] = '{5'd2, 5, 8'hA5, 8'h01, 2};
    vt[2] = '{5'd0, 0, 8'h00, 8'h01, 32};
    vt[3] = '{5'd1, 1, 8'hFE, 8'h03, 1};
    vt[4] = '{5'd7, 2, 8'h40, 8'h09, 7};
    Reset = 1'b0; Start = 1'b0; DataValid = 1'b0; Halt = 1'b0; Len = 5'd0; DataIn = 8'h00;
    repeat (2) tick;
    chk("rst_ready", DataReady, 0); chk("rst_wr", MemWr, 0); chk("rst_run", CpuRun, 0);
    chk("rst_busy", Busy, 0); chk("rst_done", Done, 0); chk("rst_err", Err, 0);
    chk("rst_addr", MemAddr, 0); chk("rst_data", MemData, 0);
    Reset = 1'b1; repeat (3) tick;
    chk("idle_busy", Busy, 0); chk("idle_ready", DataReady, 0);
    Halt = 1'b1; tick; Halt = 1'b0;
    chk("halt_ign_run", CpuRun, 0); chk("halt_ign_busy", Busy, 0);
    // reset in the middle of a load
    Start = 1'b1; Len = 5'd4; tick; Start = 1'b0;
    DataValid = 1'b1; DataIn = 8'h5A; tick;
    DataIn = 8'h5B; tick;
    chk("mid_wr1", MemWr, 1); chk("mid_addr1", MemAddr, 1);
    DataIn = 8'h5C;
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_wr", MemWr, 0); chk("mid_rst_busy", Busy, 0); chk("mid_rst_ready", DataReady, 0);
    chk("mid_rst_addr", MemAddr, 0); chk("mid_rst_data", MemData, 0); chk("mid_rst_done", Done, 0);
    chk("mid_rst_run", CpuRun, 0);
    tick;
    chk("mid_rst_nowr", MemWr, 0);
    Reset = 1'b1; tick;
    chk("post_rst_wr", MemWr, 0); chk("post_rst_busy", Busy, 0);
    DataValid = 1'b0;
    foreach (vt[v]) begin
      run_load(vt[v].len, vt[v].gap, vt[v].base, vt[v].step, vt[v].exp_n);
      Start = 1'b1; Len = 5'd1; tick; Start = 1'b0;
      chk("start_ign_busy", Busy, 0); chk("start_ign_run", CpuRun, 1);
      Halt = 1'b1; tick; Halt = 1'b0;
      chk("halted_run", CpuRun, 0); chk("halted_busy", Busy, 0); chk("halted_done", Done, 0);
      tick;
      chk("halted_stay", CpuRun, 0);
    end
    run_load(5'd1, 0, 8'h77, 8'h00, 1);
    Start = 1'b1; Halt = 1'b1; Len = 5'd2; tick; Start = 1'b0; Halt = 1'b0;
    chk("sh_run", CpuRun, 0); chk("sh_busy", Busy, 0); chk("sh_ready", DataReady, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    Start = 1'b1; Len = 5'd2; tick; Start = 1'b0;
    DataValid = 1'b1; DataIn = 8'h80; tick; DataIn = 8'h90; tick;
    DataIn = 8'h11; tick; DataValid = 1'b0;
    chk("cs_bad_err", Err, 1); chk("cs_bad_run", CpuRun, 0);
    chk("cs_bad_busy", Busy, 0); chk("cs_bad_done", Done, 0);
    tick;
    chk("cs_bad_sticky", Err, 1); chk("cs_bad_idle", CpuRun, 0);
    Start = 1'b1; Len = 5'd2; tick; Start = 1'b0;
    chk("cs_err_clr", Err, 0);
    DataValid = 1'b1; DataIn = 8'h80; tick; DataIn = 8'h90; tick;
    DataIn = 8'h10; tick; DataValid = 1'b0;
    chk("cs_ok_run", CpuRun, 1); chk("cs_ok_done", Done, 1); chk("cs_ok_err", Err, 0);
`else
    chk("no_cs_err", Err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
